// File: rtl/stream_accum_sink_pkg.sv
// Shared dataflow definitions for the toy pipeline modules.
// Holds the FSM encoding and the default widths and sizes.
package stream_accum_sink_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_N_ELEMS = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_READ  = 3'b010,
        S_WRITE = 3'b100
    } state_t;

endpackage

// File: rtl/stream_accum_sink.sv
// Pops N_ELEMS words from an input FIFO, sums them (wrapping) and pushes the sum to a result FIFO,
// using an ap_ctrl_chain-style start/done/continue handshake.
module stream_accum_sink
    import stream_accum_sink_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned N_ELEMS = DEF_N_ELEMS
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] D_dout,
    input  logic              D_empty_n,
    output logic              D_read,
    output logic [DATA_W-1:0] E_din,
    input  logic              E_full_n,
    output logic              E_write
);

    localparam int unsigned     CNT_W    = $clog2(N_ELEMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ELEMS - 1);

    state_t            state;
    logic              done_reg;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;

    logic start_ok;
    logic pop;
    logic push;

    // A held done blocks new starts until downstream acknowledges it.
    assign start_ok = (state == S_IDLE) && ap_start && !done_reg;
    assign pop      = (state == S_READ) && D_empty_n;
    assign push     = (state == S_WRITE) && E_full_n;

    assign D_read   = pop;
    assign E_write  = push;
    assign E_din    = acc;
    assign ap_ready = push;
    assign ap_done  = push || done_reg;
    assign ap_idle  = (state == S_IDLE) && !ap_start;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= S_IDLE;
            done_reg <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    if (pop) begin
                        acc <= acc + D_dout;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (push) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (ap_continue) begin
                done_reg <= 1'b0;
            end else if (push) begin
                done_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_accum_sink.sv
// Self-checking bench for stream_accum_sink: directed and randomized invocations with FIFO
// stalls, checked against a queue-and-sum reference model.
module tb_stream_accum_sink;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 5;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_done;
    logic          ap_continue;
    logic          ap_idle;
    logic          ap_ready;
    logic [DW-1:0] D_dout;
    logic          D_empty_n;
    logic          D_read;
    logic [DW-1:0] E_din;
    logic          E_full_n;
    logic          E_write;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int inv_pops = 0;
    int inv_pushes = 0;

    logic [DW-1:0] dq[$];
    logic [DW-1:0] exp_sum;
    logic          d_stall = 1'b0;
    logic          e_stall = 1'b0;
    logic          s_dread;
    logic          s_ewrite;

    always #5 ap_clk = ~ap_clk;

    stream_accum_sink #(
        .DATA_W (DW),
        .N_ELEMS(N)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_continue(ap_continue),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .D_dout     (D_dout),
        .D_empty_n  (D_empty_n),
        .D_read     (D_read),
        .E_din      (E_din),
        .E_full_n   (E_full_n),
        .E_write    (E_write)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Present the FIFO model to the DUT, then sample outputs mid-cycle.
    task automatic drive_sample();
        D_empty_n = (dq.size() != 0) && !d_stall;
        D_dout    = (dq.size() != 0) ? dq[0] : '0;
        E_full_n  = !e_stall;
        #2;
        s_dread  = D_read;
        s_ewrite = E_write;
        chk("no_rd_wr_overlap", {31'b0, D_read & E_write}, 32'd0);
    endtask

    task automatic tick();
        if (s_dread === 1'b1) begin
            void'(dq.pop_front());
            inv_pops++;
        end
        if (s_ewrite === 1'b1) inv_pushes++;
        @(posedge ap_clk);
        #1;
        cycle++;
    endtask

    task automatic load5(input logic [DW-1:0] w [N]);
        exp_sum = '0;
        foreach (w[i]) begin
            dq.push_back(w[i]);
            exp_sum = exp_sum + w[i];
        end
    endtask

    task automatic invoke(input string tag, input int d_after, input int d_len, input int e_len,
                          input bit cont);
        int  acc_c;
        int  dg = 0;
        int  eg = 0;
        bit  done = 0;
        inv_pops    = 0;
        inv_pushes  = 0;
        ap_start    = 1'b1;
        ap_continue = cont;
        d_stall     = 1'b0;
        e_stall     = 1'b0;
        drive_sample();
        chk({tag, "_accept_ready"}, {31'b0, ap_ready}, 32'd0);
        acc_c = cycle;
        tick();
        ap_start = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            d_stall = (inv_pops == d_after) && (dg < d_len);
            if (d_stall) dg++;
            e_stall = (inv_pops == N) && (eg < e_len);
            if (e_stall) eg++;
            drive_sample();
            if (inv_pops == N) chk({tag, "_e_din"}, E_din, exp_sum);
            if (s_ewrite === 1'b1) begin
                done = 1;
                chk({tag, "_done"}, {31'b0, ap_done}, 32'd1);
                chk({tag, "_ready"}, {31'b0, ap_ready}, 32'd1);
                chk({tag, "_latency"}, cycle - acc_c + 1, N + 2 + d_len + e_len);
            end else begin
                chk({tag, "_early_done"}, {31'b0, ap_done}, 32'd0);
            end
            tick();
        end
        chk({tag, "_finished"}, {31'b0, done}, 32'd1);
        chk({tag, "_pops"}, inv_pops, N);
        chk({tag, "_pushes"}, inv_pushes, 1);
        d_stall = 1'b0;
        e_stall = 1'b0;
        if (cont) begin
            drive_sample();
            chk({tag, "_post_done"}, {31'b0, ap_done}, 32'd0);
            chk({tag, "_post_idle"}, {31'b0, ap_idle}, 32'd1);
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst_n    = 1'b1;
        ap_start    = 1'b0;
        ap_continue = 1'b0;
        D_dout      = '0;
        D_empty_n   = 1'b0;
        E_full_n    = 1'b1;
        #1;
        ap_rst_n = 1'b0;
        #2;
        chk("rst_idle", {31'b0, ap_idle}, 32'd1);
        chk("rst_done", {31'b0, ap_done}, 32'd0);
        chk("rst_ready", {31'b0, ap_ready}, 32'd0);
        chk("rst_e_din", E_din, 32'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        // Idle with data available must not pop
        dq.push_back(32'h1234);
        for (int i = 0; i < 10; i++) begin
            drive_sample();
            chk("idle_ap_idle", {31'b0, ap_idle}, 32'd1);
            chk("idle_d_read", {31'b0, D_read}, 32'd0);
            chk("idle_e_write", {31'b0, E_write}, 32'd0);
            tick();
        end
        dq.delete();

        load5('{32'd0, 32'd1, 32'd4, 32'd9, 32'd16});
        invoke("nominal", 0, 0, 0, 1'b1);

        load5('{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0});
        invoke("wrap_pos", 0, 0, 0, 1'b1);
        load5('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        invoke("wrap_neg", 0, 0, 0, 1'b1);

        load5('{32'd0, 32'd1, 32'd4, 32'd9, 32'd16});
        invoke("backpressure", 2, 3, 4, 1'b1);

        // Chaining: done held until ap_continue, start ignored meanwhile
        load5('{32'd10, 32'd20, 32'd30, 32'd40, 32'd50});
        invoke("chain1", 0, 0, 0, 1'b0);
        load5('{32'd1, 32'd2, 32'd3, 32'd4, 32'd5});
        ap_start    = 1'b1;
        ap_continue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_sample();
            chk("chain_hold_done", {31'b0, ap_done}, 32'd1);
            chk("chain_hold_ready", {31'b0, ap_ready}, 32'd0);
            chk("chain_hold_read", {31'b0, D_read}, 32'd0);
            tick();
        end
        ap_continue = 1'b1;
        drive_sample();
        chk("chain_cont_done", {31'b0, ap_done}, 32'd1);
        chk("chain_cont_ready", {31'b0, ap_ready}, 32'd0);
        tick();
        invoke("chain2", 0, 0, 0, 1'b1);

        // Reset mid-invocation after the third pop
        load5('{32'd7, 32'd8, 32'd9, 32'd10, 32'd11});
        inv_pops    = 0;
        inv_pushes  = 0;
        ap_start    = 1'b1;
        ap_continue = 1'b1;
        drive_sample();
        tick();
        ap_start = 1'b0;
        for (int k = 0; k < 20 && inv_pops < 3; k++) begin
            drive_sample();
            tick();
        end
        chk("rst_mid_pops", inv_pops, 3);
        ap_rst_n = 1'b0;
        #1;
        chk("rst_mid_d_read", {31'b0, D_read}, 32'd0);
        chk("rst_mid_e_write", {31'b0, E_write}, 32'd0);
        chk("rst_mid_done", {31'b0, ap_done}, 32'd0);
        chk("rst_mid_ready", {31'b0, ap_ready}, 32'd0);
        chk("rst_mid_e_din", E_din, 32'd0);
        dq.delete();
        for (int i = 0; i < 3; i++) begin
            drive_sample();
            chk("rst_hold_write", {31'b0, E_write}, 32'd0);
            tick();
        end
        chk("rst_mid_pushes", inv_pushes, 0);
        ap_rst_n = 1'b1;
        load5('{32'd100, 32'd200, 32'd300, 32'd400, 32'd500});
        invoke("after_rst", 0, 0, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            logic [DW-1:0] w [N];
            foreach (w[i]) w[i] = $urandom;
            load5(w);
            invoke("random", $urandom_range(0, N - 1), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
